// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and sizing helper for the bit-serial subtractor
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // One spare bit so the bit index can hold WIDTH itself without wrapping.
   function automatic int idx_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - LSB-first bit-serial a-b-bin with valid/ready; optional SERIAL_SUB_OVF_EN adds ovf
module serial_ripple_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int IDX_W = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             br;
   logic [IDX_W-1:0] idx;
   logic             cell_d;
   logic             cell_bo;

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits are shifted out during RUN, so keep a copy for the overflow test.
   logic a_msb;
   logic b_msb;
`endif

   full_subtractor u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (br),
      .diff (cell_d),
      .bout (cell_bo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         br        <= 1'b0;
         idx       <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  br       <= bin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb    <= a[WIDTH-1];
                  b_msb    <= b[WIDTH-1];
`endif
               end
            end

            RUN: begin
               // Result enters at the MSB so bit 0 reaches diff[0] after WIDTH shifts.
               diff <= {cell_d, diff[WIDTH-1:1]};
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= cell_bo;
               idx  <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  bout      <= cell_bo;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                  ovf       <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - directed self-checking bench for serial_ripple_subtractor
module tb_serial_ripple_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   serial_ripple_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf       (ovf),
`endif
      .bout      (bout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_in_ready();
      int n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("in_ready_wait", {31'd0, in_ready}, 32'd1);
   endtask

   // Drive one operation from accept to result handshake at negedges.
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                         input logic [W-1:0] exp_d, input logic exp_bo, input int hold,
                         input bit pulse);
      int lat = 0;
      @(negedge clk);
      wait_in_ready();
      out_ready = (hold == 0);
      a = va; b = vb; bin = vbin; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid === 1'b1) break;
         check_eq("run_in_ready", {31'd0, in_ready}, 32'd0);
         if (pulse && lat < 3) begin
            a = ~va; b = va; bin = ~vbin; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check_eq("latency", lat, 4);
      check_eq("diff", {28'd0, diff}, {28'd0, exp_d});
      check_eq("bout", {31'd0, bout}, {31'd0, exp_bo});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
         check_eq("hold_diff", {28'd0, diff}, {28'd0, exp_d});
         check_eq("hold_bout", {31'd0, bout}, {31'd0, exp_bo});
         check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check_eq("no_same_cycle_accept", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_eq("valid_drop", {31'd0, out_valid}, 32'd0);
      check_eq("in_ready_after", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic run_ovf(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] exp_d, input logic exp_ovf);
      int lat = 0;
      @(negedge clk);
      wait_in_ready();
      a = va; b = vb; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_eq("ovf_diff", {28'd0, diff}, {28'd0, exp_d});
      check_eq("ovf_bout", {31'd0, bout}, 32'd0);
      check_eq("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_diff", {28'd0, diff}, 32'd0);
      check_eq("rst_bout", {31'd0, bout}, 32'd0);
      rst_n = 1'b1;

      // out_ready high while idle/running must be harmless.
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("idle_out_ready", {31'd0, out_valid}, 32'd0);

      run_op(4'b1000, 4'b0011, 1'b0, 4'b0101, 1'b0, 0, 1'b0);
      run_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 0, 1'b1);
      run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 0, 1'b0);
      run_op(4'b1010, 4'b0110, 1'b1, 4'b0011, 1'b0, 5, 1'b0);
      run_op(4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b0, 0, 1'b0);
      run_op(4'b0000, 4'b0001, 1'b1, 4'b1110, 1'b1, 2, 1'b0);
      run_op(4'b1111, 4'b0000, 1'b1, 4'b1110, 1'b0, 0, 1'b0);

      // Abort mid-RUN: reset after the second RUN edge.
      @(negedge clk);
      a = 4'b1111; b = 4'b0001; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("abort_diff", {28'd0, diff}, 32'd0);
      check_eq("abort_bout", {31'd0, bout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'b0111, 4'b0111, 1'b0, 4'b0000, 1'b0, 0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
      run_ovf(4'b1000, 4'b0001, 4'b0111, 1'b1);
      run_ovf(4'b0111, 4'b0001, 4'b0110, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
